// File: rtl/us_timer_bank.sv
// Multi-channel microsecond timer bank: one shared 1 us prescaler
// feeding independent periodic / one-shot / square-wave channels.
module us_timer_bank #(
  parameter int CLOCK_SPEED_MHZ = 12,
  parameter int CHANNELS        = 4,
  parameter int PERIOD_WIDTH    = 16,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    wr_en,
  input  logic [CW-1:0]           wr_chan,
  input  logic [PERIOD_WIDTH-1:0] wr_period,
  input  logic [1:0]              wr_mode,
  output logic                    us_tick,
  output logic [CHANNELS-1:0]     pulse,
  output logic [CHANNELS-1:0]     level,
  output logic [CHANNELS-1:0]     active
);

  localparam int PSW = $clog2(CLOCK_SPEED_MHZ);
  localparam logic [PSW-1:0] PRE_TOP = PSW'(CLOCK_SPEED_MHZ - 1);

  typedef enum logic [1:0] {
    OFF      = 2'd0,
    PERIODIC = 2'd1,
    ONESHOT  = 2'd2,
    SQUARE   = 2'd3
  } mode_t;

  logic [PSW-1:0] pre;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pre <= '0;
    end else if (pre == PRE_TOP) begin
      pre <= '0;
    end else begin
      pre <= pre + PSW'(1);
    end
  end

  assign us_tick = (pre == PRE_TOP);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [PERIOD_WIDTH-1:0] per;
    logic [PERIOD_WIDTH-1:0] cnt;
    mode_t                   mode;
    logic                    lvl;
    logic                    pls;
    logic                    sel;
    logic                    run;
    logic                    wrap;

    assign sel  = wr_en && (wr_chan == CW'(i));
    assign run  = us_tick && (mode != OFF) && (per != '0);
    assign wrap = (cnt == per - PERIOD_WIDTH'(1));

    // A write in a tick cycle takes priority and swallows that tick.
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        per  <= '0;
        cnt  <= '0;
        mode <= OFF;
        lvl  <= 1'b0;
        pls  <= 1'b0;
      end else if (sel) begin
        per  <= wr_period;
        mode <= mode_t'(wr_mode);
        cnt  <= '0;
        lvl  <= 1'b0;
        pls  <= 1'b0;
      end else begin
        pls <= 1'b0;
        if (run) begin
          if (wrap) begin
            cnt <= '0;
            unique case (mode)
              PERIODIC: pls <= 1'b1;
              ONESHOT: begin
                pls  <= 1'b1;
                mode <= OFF;
              end
              SQUARE:  lvl <= ~lvl;
              default: ;
            endcase
          end else begin
            cnt <= cnt + PERIOD_WIDTH'(1);
          end
        end
      end
    end

    assign pulse[i]  = pls;
    assign level[i]  = lvl;
    assign active[i] = (mode != OFF);
  end

endmodule

// File: tb/tb_us_timer_bank.sv
// Self-checking bench for us_timer_bank against a tick-counting
// reference model; directed scenarios followed by random writes.
module tb_us_timer_bank;

  localparam int MHZ = 12;
  localparam int NCH = 5;
  localparam int PW  = 16;
  localparam int CW  = 3;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          wr_en = 1'b0;
  logic [CW-1:0] wr_chan = '0;
  logic [PW-1:0] wr_period = '0;
  logic [1:0]    wr_mode = '0;
  logic          us_tick;
  logic [NCH-1:0] pulse;
  logic [NCH-1:0] level;
  logic [NCH-1:0] active;

  int checks = 0;
  int errors = 0;

  int m_edges;
  int m_mode[NCH];
  int m_per[NCH];
  int m_ticks[NCH];
  int m_ev[NCH];
  bit m_pulse[NCH];

  int pcnt[NCH];
  int tcnt[NCH];
  bit prev_lvl[NCH];

  us_timer_bank #(
    .CLOCK_SPEED_MHZ(MHZ),
    .CHANNELS(NCH),
    .PERIOD_WIDTH(PW)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .wr_en(wr_en),
    .wr_chan(wr_chan),
    .wr_period(wr_period),
    .wr_mode(wr_mode),
    .us_tick(us_tick),
    .pulse(pulse),
    .level(level),
    .active(active)
  );

  always #5 CLK = ~CLK;

  function automatic bit tick_now();
    return (m_edges % MHZ) == MHZ - 1;
  endfunction

  task automatic model_reset();
    m_edges = 0;
    for (int i = 0; i < NCH; i++) begin
      m_mode[i] = 0;
      m_per[i] = 0;
      m_ticks[i] = 0;
      m_ev[i] = 0;
      m_pulse[i] = 0;
    end
  endtask

  // Events fire whenever the accepted-tick count reaches a multiple of P.
  task automatic model_edge();
    bit t;
    t = tick_now();
    m_edges++;
    for (int i = 0; i < NCH; i++) begin
      if (wr_en && int'(wr_chan) == i) begin
        m_mode[i] = int'(wr_mode);
        m_per[i] = int'(wr_period);
        m_ticks[i] = 0;
        m_ev[i] = 0;
        m_pulse[i] = 0;
      end else begin
        m_pulse[i] = 0;
        if (t && m_mode[i] != 0 && m_per[i] != 0) begin
          m_ticks[i]++;
          if (m_ticks[i] % m_per[i] == 0) begin
            if (m_mode[i] == 1) m_pulse[i] = 1;
            if (m_mode[i] == 2) begin
              m_pulse[i] = 1;
              m_mode[i] = 0;
            end
            if (m_mode[i] == 3) m_ev[i]++;
          end
        end
      end
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [NCH-1:0] ep, el, ea;
    ep = '0;
    el = '0;
    ea = '0;
    for (int i = 0; i < NCH; i++) begin
      ep[i] = m_pulse[i];
      el[i] = (m_ev[i] % 2) == 1;
      ea[i] = m_mode[i] != 0;
    end
    chk("us_tick", 32'(us_tick), 32'(tick_now()));
    chk("pulse", 32'(pulse), 32'(ep));
    chk("level", 32'(level), 32'(el));
    chk("active", 32'(active), 32'(ea));
    for (int i = 0; i < NCH; i++) begin
      pcnt[i] += int'(pulse[i]);
      if (level[i] !== prev_lvl[i]) tcnt[i]++;
      prev_lvl[i] = level[i];
    end
  endtask

  task automatic clr_counts();
    for (int i = 0; i < NCH; i++) begin
      pcnt[i] = 0;
      tcnt[i] = 0;
    end
  endtask

  task automatic cycle();
    @(posedge CLK);
    if (RST_N) model_edge();
    #1;
    check_all();
  endtask

  task automatic run(int n);
    repeat (n) cycle();
  endtask

  task automatic wr(int ch, int p, int m);
    wr_chan = CW'(ch);
    wr_period = PW'(p);
    wr_mode = 2'(m);
    wr_en = 1'b1;
    cycle();
    wr_en = 1'b0;
  endtask

  initial begin
    int n;
    model_reset();
    for (int i = 0; i < NCH; i++) prev_lvl[i] = 0;
    clr_counts();

    // Reset and free-running prescaler
    run(5);
    RST_N = 1'b1;
    run(40);

    // Periodic: P=3 gives pulses after the 3rd, 6th, 9th tick
    clr_counts();
    wr(0, 3, 1);
    run(120);
    chk("periodic_count", 32'(pcnt[0]), 32'd3);
    chk("periodic_active", 32'(active[0]), 32'd1);

    // One-shot: a single pulse, then inactive
    clr_counts();
    wr(1, 2, 2);
    run(150);
    chk("oneshot_count", 32'(pcnt[1]), 32'd1);
    chk("oneshot_active", 32'(active[1]), 32'd0);

    // Square: 5-tick half period, no pulses
    clr_counts();
    wr(2, 5, 3);
    run(130);
    chk("square_toggles", 32'(tcnt[2]), 32'd2);
    chk("square_pulses", 32'(pcnt[2]), 32'd0);

    // Write colliding with a tick: that tick is swallowed
    while (!tick_now()) cycle();
    wr(3, 1, 1);
    n = 0;
    while (pulse[3] !== 1'b1 && n < 40) begin
      cycle();
      n++;
    end
    chk("collision_latency", 32'(n), 32'd12);

    // P=0: active but idle
    clr_counts();
    wr(4, 0, 1);
    run(100);
    chk("p0_active", 32'(active[4]), 32'd1);
    chk("p0_pulses", 32'(pcnt[4]), 32'd0);

    // Out-of-range channel indices change nothing
    wr(5, 1, 0);
    wr(6, 2, 2);
    wr(7, 1, 3);
    run(30);

    // Random writes
    for (int k = 0; k < 60; k++) begin
      wr(int'($urandom_range(0, 7)), int'($urandom_range(0, 6)),
         int'($urandom_range(0, 3)));
      run(int'($urandom_range(0, 40)));
    end

    // Asynchronous reset between edges while ch0 runs
    wr(0, 2, 1);
    run(20);
    @(posedge CLK);
    model_edge();
    #2;
    RST_N = 1'b0;
    #1;
    model_reset();
    chk("async_rst_tick", 32'(us_tick), 32'd0);
    chk("async_rst_active", 32'(active), 32'd0);
    check_all();
    run(3);
    RST_N = 1'b1;
    clr_counts();
    run(60);
    chk("post_rst_pulses", 32'(pcnt[0]), 32'd0);
    chk("post_rst_active", 32'(active), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
